// File: rtl/voice_mixer_pkg.sv
// Shared audio package for the voice mixer: default widths, FSM encoding
// and the accumulator/index width helpers.
package voice_mixer_pkg;

   localparam int DEFAULT_NUM_VOICES = 3;
   localparam int DEFAULT_SAMPLE_W   = 16;
   localparam int DEFAULT_SHIFT_W    = 2;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      ACCUM   = 2'd1,
      OUT     = 2'd2
   } mix_state_t;

   // One guard bit per doubling of the voice count, plus one so the
   // most negative sum of NUM_VOICES full-scale samples still fits.
   function automatic int acc_width(input int num_voices, input int sample_w);
      return sample_w + $clog2(num_voices) + 1;
   endfunction

   function automatic int index_width(input int num_voices);
      return (num_voices > 1) ? $clog2(num_voices) : 1;
   endfunction

endpackage

// File: rtl/voice_mixer_sat_reduce.sv
// Saturating reducer: narrows a signed value to OUT_W bits, clamping to
// the most positive / most negative code when it does not fit.
module sat_reduce #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    saturated
);

   localparam logic signed [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

   logic [IN_W-OUT_W:0] top_bits;

   // The value fits only if every bit above the output sign bit matches it.
   always_comb begin
      top_bits  = din[IN_W-1:OUT_W-1];
      saturated = !((top_bits == '0) || (top_bits == '1));
      if (!saturated)
         dout = din[OUT_W-1:0];
      else if (din[IN_W-1])
         dout = MIN_VAL;
      else
         dout = MAX_VAL;
   end

endmodule

// File: rtl/voice_mixer.sv
// Multi-voice mixer: collects one strobed sample per enabled voice, then
// sums the attenuated samples one voice per cycle and emits a saturated mix.
module voice_mixer
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
   parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
   parameter int SHIFT_W    = DEFAULT_SHIFT_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_ready,
   input  logic [NUM_VOICES-1:0]          voice_enable,
   input  logic [NUM_VOICES*SHIFT_W-1:0]  voice_shift,
   input  logic                           clip_clear,
   output logic [SAMPLE_W-1:0]            mix_sample,
   output logic                           mix_valid,
   output logic                           clip,
   output logic                           overrun,
   output logic                           busy
);

   localparam int ACC_W = acc_width(NUM_VOICES, SAMPLE_W);
   localparam int IDX_W = index_width(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   mix_state_t state, state_next;

   logic [SAMPLE_W-1:0]    capture  [NUM_VOICES];
   logic [NUM_VOICES-1:0]  pending;
   logic [SAMPLE_W-1:0]    mix_bank [NUM_VOICES];
   logic [SHIFT_W-1:0]     mix_shift[NUM_VOICES];
   logic [NUM_VOICES-1:0]  mix_en;
   logic [IDX_W-1:0]       idx;
   logic signed [ACC_W-1:0] acc;

   logic                    start_frame;
   logic signed [SAMPLE_W-1:0] shifted;
   logic signed [ACC_W-1:0] addend;
   logic signed [SAMPLE_W-1:0] sat_value;
   logic                    sat_hit;

   // A strobe arriving this cycle counts toward completing the frame.
   assign start_frame = (state == COLLECT) && (|voice_enable) &&
                        (&(pending | voice_ready | ~voice_enable));
   assign busy = (state != COLLECT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= COLLECT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (start_frame) state_next = ACCUM;
         ACCUM:   if (idx == LAST_IDX) state_next = OUT;
         OUT:     state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   // Capture bank keeps loading in every state so the next frame can fill
   // while the current one is being summed from the mix bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) capture[i] <= '0;
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++)
            if (voice_ready[i]) capture[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
         pending <= start_frame ? '0 : (pending | voice_ready);
         overrun <= |(voice_ready & pending);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            mix_bank[i]  <= '0;
            mix_shift[i] <= '0;
         end
         mix_en <= '0;
      end else if (start_frame) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            mix_bank[i]  <= voice_ready[i] ? voice_sample[i*SAMPLE_W +: SAMPLE_W]
                                           : capture[i];
            mix_shift[i] <= voice_shift[i*SHIFT_W +: SHIFT_W];
         end
         mix_en <= voice_enable;
      end
   end

   always_comb begin
      shifted = $signed(mix_bank[idx]) >>> mix_shift[idx];
      addend  = {{(ACC_W-SAMPLE_W){shifted[SAMPLE_W-1]}}, shifted};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         idx <= '0;
      end else if (start_frame) begin
         acc <= '0;
         idx <= '0;
      end else if (state == ACCUM) begin
         if (mix_en[idx]) acc <= acc + addend;
         idx <= idx + IDX_W'(1);
      end
   end

   sat_reduce #(
      .IN_W  (ACC_W),
      .OUT_W (SAMPLE_W)
   ) u_sat (
      .din       (acc),
      .dout      (sat_value),
      .saturated (sat_hit)
   );

   // clip_clear wins over a clip raised by the same frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mix_sample <= '0;
         mix_valid  <= 1'b0;
         clip       <= 1'b0;
      end else begin
         mix_valid <= (state == OUT);
         if (state == OUT) mix_sample <= sat_value;
         if (clip_clear)
            clip <= 1'b0;
         else if ((state == OUT) && sat_hit)
            clip <= 1'b1;
      end
   end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 3, number of voice channels mixed (1..16).
REQ-002 Parameter SAMPLE_W, default 16, two's-complement sample width of each voice and of the mix.
REQ-003 Parameter SHIFT_W, default 2, width of each voice's attenuation shift field.
REQ-004 Port clk, input, 1, single system clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port voice_sample, input, NUM_VOICES*SAMPLE_W, per-voice signed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
REQ-007 Port voice_ready, input, NUM_VOICES, per-voice one-cycle strobe meaning the matching voice_sample slice is valid.
REQ-008 Port voice_enable, input, NUM_VOICES, per-voice mix enable.
REQ-009 Port voice_shift, input, NUM_VOICES*SHIFT_W, per-voice arithmetic right-shift amount.
REQ-010 Port clip_clear, input, 1, clears the sticky clip flag.
REQ-011 Port mix_sample, output, SAMPLE_W, last saturated mixed sample, held between frames.
REQ-012 Port mix_valid, output, 1, one-cycle strobe when mix_sample updates.
REQ-013 Port clip, output, 1, sticky flag set when any mix saturates.
REQ-014 Port overrun, output, 1, one-cycle strobe when a voice strobes twice within one collection frame.
REQ-015 Port busy, output, 1, high while in ACCUM or OUT.

Function
REQ-016 The block has a capture bank (NUM_VOICES sample registers plus a pending bit per voice) and a separate mix bank.
REQ-017 voice_ready[i] in any state loads capture[i] and sets pending[i] in the same edge.
REQ-018 If voice_ready[i] arrives while pending[i] is already set, capture[i] is overwritten and overrun pulses on the next cycle.
REQ-019 FSM states are COLLECT (reset state), ACCUM and OUT.
REQ-020 COLLECT->ACCUM occurs when voice_enable is nonzero and (pending | ~voice_enable) is all ones, where pending includes any voice_ready present that cycle.
REQ-021 On the COLLECT->ACCUM edge the block copies the capture bank, voice_enable and voice_shift into the mix bank, clears pending, and zeroes the accumulator.
REQ-022 A voice_ready on the same edge as COLLECT->ACCUM goes to the current frame only; pending is not set for the next frame.
REQ-023 In ACCUM, one voice index k (0..NUM_VOICES-1) is processed per cycle: if snapshot-enabled, acc += (sample_k >>> shift_k), sign-extended to ACC_W = SAMPLE_W + clog2(NUM_VOICES) + 1; otherwise acc is unchanged.
REQ-024 ACCUM->OUT follows processing of index NUM_VOICES-1; OUT->COLLECT is unconditional after one cycle.
REQ-025 In OUT, mix_sample takes acc saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], mix_valid pulses, and clip is set if saturation occurred.
REQ-026 Latency is NUM_VOICES+1 cycles from the completing voice_ready edge to mix_valid.
REQ-027 voice_ready, voice_enable and voice_shift changes during ACCUM/OUT do not affect the frame in progress.
REQ-028 With voice_enable all zero, no frame is produced and pending bits keep accumulating.
REQ-029 clip_clear has priority over a simultaneous clip set, and clears clip on the next edge.

Reset
REQ-030 Asserting reset (low) immediately forces COLLECT, clears pending, capture, mix bank and accumulator, and drives mix_sample=0, mix_valid=0, clip=0, overrun=0, busy=0.
REQ-031 Reset asserted mid-ACCUM discards the frame with no mix_valid pulse; operation resumes from COLLECT on the first edge after deassertion.

Structure
REQ-032 The FSM state encodings and the ACC_W computation are defined in the shared audio package next to the sample-width constants.
REQ-033 The saturating width reducer is a separate sub-module, sat_reduce, parameterised by input and output width.

Verification (NUM_VOICES=3, SAMPLE_W=16)
REQ-034 Scenario: all voices enabled, shift=2, samples 0x4000 strobed in the same cycle -> mix_sample=0x3000, mix_valid exactly 4 cycles later, clip=0.
REQ-035 Scenario: shift=0, samples 0x7000 x3 -> mix_sample=0x7FFF, clip=1; the next frame with 0x0100 x3 gives mix_sample=0x0300 with clip still 1 until clip_clear.
REQ-036 Scenario: shift=0, samples 0x8000 x3 -> mix_sample=0x8000, clip=1.
REQ-037 Scenario: voice 1 disabled, voices 0 and 2 strobe 0x1000 at shift 0 on different cycles -> mix_sample=0x2000 after the second strobe, without waiting for voice 1.
REQ-038 Scenario: voice 0 strobes twice before voices 1 and 2 -> one overrun pulse, and the mix uses the second voice 0 sample.
REQ-039 Scenario: reset pulsed low during ACCUM -> no mix_valid, all outputs 0; the next complete frame mixes correctly.
